// File: rtl/umem_arbiter.sv
// rtl/umem_arbiter.sv - fetch/data arbiter sequencing 32-bit words onto an 8-bit unified memory
//
// Shares a single-ported 256x8 synchronous memory between the instruction
// fetch port (read only) and the load/store data port. Each granted word is
// moved as four byte beats at addr+0..addr+3 (wrapping mod 256) and is
// assembled little-endian. Completion is a one-cycle ack on the winning port.
//
// Ports:
//   clk, nreset                     clock (rising edge), async active-low reset
//   i_req, i_addr                   fetch request and byte address
//   i_ack, i_rdata                  fetch completion pulse and fetched word
//   d_req, d_we, d_addr, d_wdata    data request, write flag, address, write word
//   d_ack, d_rdata                  data completion pulse and read word (0 on writes)
//   mem_en, mem_we                  memory strobe and byte write enable
//   mem_addr, mem_wdata             memory byte address and write byte
//   mem_rdata                       memory read byte, valid the cycle after mem_en
//   busy                            high while a transaction is in flight
//
// Build option:
//   UMEM_ARB_RR_EN  defined   -> round-robin between fetch and data on ties
//                   undefined -> fixed priority, data always wins

module umem_arbiter (
    input  logic        clk,
    input  logic        nreset,
    input  logic        i_req,
    input  logic [7:0]  i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [7:0]  d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_LAST = 2'd2,
        S_ACK  = 2'd3
    } state_t;

    state_t      r_state;
    logic [1:0]  r_beat;
    logic        r_win_d;
    logic [7:0]  r_addr;
    logic        r_we;
    logic [31:0] r_wdata;
    logic [23:0] r_rbuf;

    logic        w_in_ack;
    logic        w_can_grant;
    logic        w_i_req;
    logic        w_d_req;
    logic        w_grant_any;
    logic        w_grant_d;
    logic [7:0]  w_next_addr;
    logic        w_next_we;
    logic [31:0] w_next_wdata;
    logic [1:0]  w_nbeat;
    logic [1:0]  w_cap_idx;

    assign w_in_ack    = (r_state == S_ACK);
    assign w_can_grant = (r_state == S_IDLE) || w_in_ack;

    // The port being acked this cycle is still holding its request; hide it
    // so it cannot be re-granted on its own stale request.
    assign w_i_req = i_req & ~(w_in_ack & ~r_win_d);
    assign w_d_req = d_req & ~(w_in_ack &  r_win_d);

`ifdef UMEM_ARB_RR_EN
    logic r_last_d;

    assign w_grant_any = w_i_req | w_d_req;
    assign w_grant_d   = (w_i_req & w_d_req) ? ~r_last_d : w_d_req;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_last_d <= 1'b0;
        end else if (w_can_grant && w_grant_any) begin
            r_last_d <= w_grant_d;
        end
    end
`else
    // Fixed priority looks at the raw d_req: while data keeps requesting,
    // even during its own ack cycle, fetch is never granted.
    assign w_grant_any = w_d_req | (w_i_req & ~d_req);
    assign w_grant_d   = w_d_req;
`endif

    assign w_next_addr  = w_grant_d ? d_addr : i_addr;
    assign w_next_we    = w_grant_d & d_we;
    assign w_next_wdata = w_grant_d ? d_wdata : 32'd0;
    assign w_nbeat      = r_beat + 2'd1;
    assign w_cap_idx    = r_beat - 2'd1;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state   <= S_IDLE;
            r_beat    <= 2'd0;
            r_win_d   <= 1'b0;
            r_addr    <= 8'd0;
            r_we      <= 1'b0;
            r_wdata   <= 32'd0;
            r_rbuf    <= 24'd0;
            i_ack     <= 1'b0;
            i_rdata   <= 32'd0;
            d_ack     <= 1'b0;
            d_rdata   <= 32'd0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 8'd0;
            mem_wdata <= 8'd0;
            busy      <= 1'b0;
        end else begin
            // Acks and returned words are single-cycle pulses.
            i_ack   <= 1'b0;
            i_rdata <= 32'd0;
            d_ack   <= 1'b0;
            d_rdata <= 32'd0;

            case (r_state)
                S_IDLE, S_ACK: begin
                    if (w_grant_any) begin
                        r_state   <= S_XFER;
                        r_beat    <= 2'd0;
                        r_win_d   <= w_grant_d;
                        r_addr    <= w_next_addr;
                        r_we      <= w_next_we;
                        r_wdata   <= w_next_wdata;
                        r_rbuf    <= 24'd0;
                        mem_en    <= 1'b1;
                        mem_we    <= w_next_we;
                        mem_addr  <= w_next_addr;
                        mem_wdata <= w_next_wdata[7:0];
                        busy      <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        busy    <= 1'b0;
                    end
                end

                S_XFER: begin
                    // Read data lags the strobe by one cycle: beat k's byte
                    // arrives while beat k+1 is on the bus.
                    if (r_beat != 2'd0) begin
                        r_rbuf[{w_cap_idx, 3'b000} +: 8] <= mem_rdata;
                    end
                    if (r_beat == 2'd3) begin
                        r_state <= S_LAST;
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                    end else begin
                        r_beat    <= w_nbeat;
                        mem_addr  <= r_addr + {6'd0, w_nbeat};
                        mem_wdata <= r_wdata[{w_nbeat, 3'b000} +: 8];
                    end
                end

                S_LAST: begin
                    r_state <= S_ACK;
                    if (r_win_d) begin
                        d_ack   <= 1'b1;
                        d_rdata <= r_we ? 32'd0 : {mem_rdata, r_rbuf};
                    end else begin
                        i_ack   <= 1'b1;
                        i_rdata <= {mem_rdata, r_rbuf};
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_umem_arbiter.sv
// tb/tb_umem_arbiter.sv - scoreboard bench for umem_arbiter against a word-level memory model

module tb_umem_arbiter;

    logic        clk;
    logic        nreset;
    logic        i_req;
    logic [7:0]  i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;

    umem_arbiter dut (
        .clk       (clk),
        .nreset    (nreset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    typedef struct {
        bit          port_d;
        logic [31:0] rdata;
        int          cyc;
    } ack_t;

    typedef struct {
        logic [7:0] addr;
        bit         we;
        logic [7:0] wdata;
        int         cyc;
    } beat_t;

    ack_t  ackq[$];
    beat_t beatq[$];

    logic [7:0] phys_mem [256];
    logic [7:0] ref_mem  [256];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port memory behind the arbiter.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) phys_mem[mem_addr] <= mem_wdata;
            mem_rdata <= phys_mem[mem_addr];
        end
    end

    function automatic logic [31:0] ref_word(input logic [7:0] a);
        logic [31:0] w;
        logic [7:0]  ad;
        w = 32'd0;
        for (int k = 0; k < 4; k++) begin
            ad = a + 8'(k);
            w[8*k +: 8] = ref_mem[ad];
        end
        return w;
    endfunction

    task automatic push_expect(input bit pd, input bit we, input logic [7:0] a,
                               input logic [31:0] wd, input logic [31:0] rd, input int c0);
        ack_t  e;
        beat_t b;
        for (int k = 0; k < 4; k++) begin
            b.addr  = a + 8'(k);
            b.we    = we;
            b.wdata = wd[8*k +: 8];
            b.cyc   = c0 + 1 + k;
            beatq.push_back(b);
        end
        e.port_d = pd;
        e.rdata  = rd;
        e.cyc    = c0 + 6;
        ackq.push_back(e);
    endtask

    // Monitor: every ack and every memory beat is matched against the scoreboard.
    always @(negedge clk) begin
        if (nreset) begin
            if (i_ack || d_ack) begin
                ack_t e;
                tests++;
                if (i_ack && d_ack) begin
                    fails++;
                    $display("FAIL ack_both: i_ack=%0b d_ack=%0b, required only one", i_ack, d_ack);
                end else if (ackq.size() == 0) begin
                    fails++;
                    $display("FAIL ack_unexpected: i_ack=%0b d_ack=%0b at cycle %0d, required none", i_ack, d_ack, cyc);
                end else begin
                    e = ackq.pop_front();
                    if (e.port_d != d_ack || e.cyc != cyc ||
                        (d_ack ? d_rdata : i_rdata) !== e.rdata) begin
                        fails++;
                        $display("FAIL ack: got port_d=%0b rdata=%h cycle=%0d, required port_d=%0b rdata=%h cycle=%0d",
                                 d_ack, (d_ack ? d_rdata : i_rdata), cyc, e.port_d, e.rdata, e.cyc);
                    end
                end
            end
            if (mem_en) begin
                beat_t b;
                tests++;
                if (beatq.size() == 0) begin
                    fails++;
                    $display("FAIL beat_unexpected: mem_addr=%h at cycle %0d, required no beat", mem_addr, cyc);
                end else begin
                    b = beatq.pop_front();
                    if (b.addr !== mem_addr || b.we !== mem_we || b.cyc != cyc ||
                        (b.we && b.wdata !== mem_wdata)) begin
                        fails++;
                        $display("FAIL beat: got addr=%h we=%0b wdata=%h cycle=%0d, required addr=%h we=%0b wdata=%h cycle=%0d",
                                 mem_addr, mem_we, mem_wdata, cyc, b.addr, b.we, b.wdata, b.cyc);
                    end
                end
            end
        end
    end

    task automatic check_outputs_zero(input string name);
        tests++;
        if ({i_ack, d_ack, mem_en, mem_we, busy, i_rdata, d_rdata, mem_addr, mem_wdata} !== '0) begin
            fails++;
            $display("FAIL %s: ack=%0b/%0b en=%0b we=%0b busy=%0b irdata=%h drdata=%h addr=%h wdata=%h, required all 0",
                     name, i_ack, d_ack, mem_en, mem_we, busy, i_rdata, d_rdata, mem_addr, mem_wdata);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // One isolated transaction, issued at a negedge while the arbiter is idle.
    task automatic do_txn(input bit pd, input bit we, input logic [7:0] a, input logic [31:0] wd);
        logic [31:0] rd;
        bit          got;
        int          c0;
        c0 = cyc;
        if (pd && we) begin
            for (int k = 0; k < 4; k++) ref_mem[8'(a + 8'(k))] = wd[8*k +: 8];
            rd = 32'd0;
        end else begin
            rd = ref_word(a);
        end
        push_expect(pd, pd && we, a, (pd ? wd : 32'd0), rd, c0);
        if (pd) begin
            d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        end else begin
            i_req = 1'b1; i_addr = a;
        end
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (n == 0) begin
                // Latched at grant; later changes must not matter.
                d_addr = 8'($urandom); d_wdata = $urandom; i_addr = 8'($urandom);
            end
            if (pd ? d_ack : i_ack) got = 1'b1;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL ack_timeout: port_d=%0b addr=%h got no ack, required ack", pd, a);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] old42, old43;
        int         c0;
        logic [31:0] wd_i, wd_d;

        for (int i = 0; i < 256; i++) begin
            phys_mem[i] = 8'(i * 37 + 5);
            ref_mem[i]  = 8'(i * 37 + 5);
        end
        mem_rdata = 8'd0;
        nreset = 1'b0;
        i_req = 1'b0; i_addr = 8'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 8'd0; d_wdata = 32'd0;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset_held");
        nreset = 1'b1;
        @(negedge clk);
        check_outputs_zero("reset_released");

        // Directed word write, then fetch of the same word.
        do_txn(1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
        check_val("mem_0x10", {phys_mem[8'h13], phys_mem[8'h12], phys_mem[8'h11], phys_mem[8'h10]}, 32'hDEADBEEF);
        do_txn(1'b0, 1'b0, 8'h10, 32'h0);

        // Wrapping word across 0xFF -> 0x00.
        do_txn(1'b1, 1'b1, 8'hFE, 32'h44332211);
        check_val("ref_wrap", ref_word(8'hFE), 32'h44332211);
        do_txn(1'b1, 1'b0, 8'hFE, 32'hA5A5A5A5);

        // Busy window for a single fetch.
        c0 = cyc;
        push_expect(1'b0, 1'b0, 8'h10, 32'd0, ref_word(8'h10), c0);
        check_val("busy_c0", {31'd0, busy}, 32'd0);
        i_req = 1'b1; i_addr = 8'h10;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check_val($sformatf("busy_c%0d", k), {31'd0, busy}, (k <= 6) ? 32'd1 : 32'd0);
            if (k == 6) i_req = 1'b0;
        end

        // Randomized isolated traffic.
        for (int t = 0; t < 40; t++) begin
            bit pd;
            pd = 1'($urandom);
            do_txn(pd, pd ? 1'($urandom) : 1'b0, 8'($urandom), $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset during beat 2 of a write to 0x40.
        old42 = ref_mem[8'h42];
        old43 = ref_mem[8'h43];
        c0 = cyc;
        wd_d = 32'h11223344;
        for (int k = 0; k < 2; k++) begin
            beat_t b;
            b.addr = 8'h40 + 8'(k); b.we = 1'b1; b.wdata = wd_d[8*k +: 8]; b.cyc = c0 + 1 + k;
            beatq.push_back(b);
        end
        ref_mem[8'h40] = 8'h44;
        ref_mem[8'h41] = 8'h33;
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h40; d_wdata = wd_d;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 nreset = 1'b0;
        #1 check_outputs_zero("reset_mid_xfer");
        d_req = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        repeat (3) @(negedge clk);
        check_val("abort_0x40", {24'd0, phys_mem[8'h40]}, 32'h44);
        check_val("abort_0x41", {24'd0, phys_mem[8'h41]}, 32'h33);
        check_val("abort_0x42", {24'd0, phys_mem[8'h42]}, {24'd0, old42});
        check_val("abort_0x43", {24'd0, phys_mem[8'h43]}, {24'd0, old43});

        // Both ports requesting continuously from a fresh reset.
        c0 = cyc;
        wd_d = ref_word(8'h20);
        wd_i = ref_word(8'h80);
`ifdef UMEM_ARB_RR_EN
        for (int j = 0; j < 4; j++) begin
            if (j % 2 == 0) push_expect(1'b1, 1'b0, 8'h20, 32'd0, wd_d, c0 + 6 * j);
            else            push_expect(1'b0, 1'b0, 8'h80, 32'd0, wd_i, c0 + 6 * j);
        end
`else
        for (int j = 0; j < 3; j++) push_expect(1'b1, 1'b0, 8'h20, 32'd0, wd_d, c0 + 7 * j);
        push_expect(1'b0, 1'b0, 8'h80, 32'd0, wd_i, c0 + 20);
`endif
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20; d_wdata = 32'd0;
        i_req = 1'b1; i_addr = 8'h80;
`ifdef UMEM_ARB_RR_EN
        while (cyc < c0 + 24) @(negedge clk);
        d_req = 1'b0;
        i_req = 1'b0;
`else
        while (cyc < c0 + 20) @(negedge clk);
        d_req = 1'b0;
        while (cyc < c0 + 26) @(negedge clk);
        i_req = 1'b0;
`endif
        repeat (4) @(negedge clk);

        check_val("ackq_drained", 32'(ackq.size()), 32'd0);
        check_val("beatq_drained", 32'(beatq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
